// File: rtl/func_test_sequencer_if.sv
// Command/capture bus between the functional-test sequencer and the
// functional-test block. The sequencer side drives bytes and read strobes;
// the functional-test side returns captured bytes, availability and its state.
interface func_test_sequencer_if;
  logic [7:0]  master_data;
  logic [4:0]  valid_bus;
  logic [4:0]  rdreq_bus;
  logic [4:0]  have_msg_bus;
  logic [39:0] slave_data_bus;
  logic [2:0]  dut_state;

  modport master (
    output master_data,
    output valid_bus,
    output rdreq_bus,
    input  have_msg_bus,
    input  slave_data_bus,
    input  dut_state
  );

  modport slave (
    input  master_data,
    input  valid_bus,
    input  rdreq_bus,
    output have_msg_bus,
    output slave_data_bus,
    output dut_state
  );
endinterface

// File: rtl/func_test_sequencer.sv
// Autonomous functional-test sequencer (DAC/BOS loopback).
// Replaces the PC on the byte command interface: writes black level and
// repetitions, streams a generated 14-bit ramp, runs the DAC pass, then drains
// the captured bytes while counting them and summing them modulo 2**16.
// Optional build macro SEQ_TIMEOUT_EN adds a 21-bit watchdog on every wait
// condition; without it waits are unbounded and only abort leaves them.
// Abort is honoured in the active states (CFG through READ); DONE and ABORTED
// already return to IDLE on the next edge.
module func_test_sequencer #(
  parameter int N_SAMPLES_MAX = 256
`ifdef SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
  input  logic                   sys_clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   ccd_mode,
  input  logic [13:0]            black_level,
  input  logic [7:0]             num_reps,
  input  logic [8:0]             num_samples,
  input  logic [13:0]            pat_base,
  input  logic [13:0]            pat_step,
  func_test_sequencer_if.master  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            rx_count,
  output logic [15:0]            checksum
);

  localparam int SMP_W = $clog2(N_SAMPLES_MAX + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_CTRL_ST,
    ST_SAMPLES,
    ST_CTRL_SP,
    ST_WAIT_DAC,
    ST_CTRL_RQ,
    ST_READ,
    ST_DONE,
    ST_ABORTED
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [SMP_W-1:0]   smp_next;
  logic [SMP_W-1:0]   n_samples_q, n_samples_d;
  logic [8:0]         ns_eff;
  logic [13:0]        sample_q, sample_d;
  logic [13:0]        step_q, step_d;
  logic [13:0]        black_q, black_d;
  logic [7:0]         reps_q, reps_d;
  logic               ccd_q, ccd_d;
  logic [7:0]         data_q, data_d;
  logic [4:0]         valid_q, valid_d;
  logic               rdreq_q, rdreq_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [15:0]        rx_count_q, rx_count_d;
  logic [15:0]        checksum_q, checksum_d;
  logic               wd_expired;
  logic               unused_bits;

  assign smp_next    = smp_cnt_q + 1'b1;
  assign unused_bits = ^{bus.slave_data_bus[31:0], bus.have_msg_bus[3:0]};

  // Ramp length of 0 runs one sample; lengths beyond the sample counter clamp
  always_comb begin
    ns_eff = num_samples;
    if (num_samples == 9'd0) begin
      ns_eff = 9'd1;
    end else if (32'(num_samples) > N_SAMPLES_MAX) begin
      ns_eff = 9'(N_SAMPLES_MAX);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic        waiting;
  logic [20:0] wd_q, wd_d;

  // Cycles where progress depends only on the functional-test block
  always_comb begin
    waiting = 1'b0;
    case (state_q)
      ST_CTRL_ST, ST_CTRL_RQ: waiting = (byte_cnt_q != 2'd0);
      ST_WAIT_DAC:            waiting = 1'b1;
      ST_READ:                waiting = !bus.have_msg_bus[4] && !rdreq_q;
      default:                waiting = 1'b0;
    endcase
  end

  assign wd_expired = waiting && (wd_q >= 21'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on any state change, any read, or any productive cycle
  always_comb begin
    wd_d = wd_q + 21'd1;
    if (!waiting || rdreq_q || (state_d != state_q)) begin
      wd_d = '0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state, byte issue and capture accounting for the sequencer
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    n_samples_d = n_samples_q;
    sample_d    = sample_q;
    step_d      = step_q;
    black_d     = black_q;
    reps_d      = reps_q;
    ccd_d       = ccd_q;
    data_d      = data_q;
    valid_d     = 5'b00000;
    rdreq_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    rx_count_d  = rx_count_q;
    checksum_d  = checksum_q;

    if (rdreq_q) begin
      rx_count_d = (rx_count_q == 16'hFFFF) ? rx_count_q : rx_count_q + 16'd1;
      checksum_d = checksum_q + {8'h00, bus.slave_data_bus[39:32]};
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          black_d     = black_level;
          reps_d      = num_reps;
          ccd_d       = ccd_mode;
          n_samples_d = SMP_W'(ns_eff);
          sample_d    = pat_base;
          step_d      = pat_step;
          rx_count_d  = '0;
          checksum_d  = '0;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          byte_cnt_d  = 2'd0;
          smp_cnt_d   = '0;
          state_d     = ST_CFG;
        end
      end
      ST_CFG: begin
        valid_d = 5'b00100;
        case (byte_cnt_q)
          2'd0:    data_d = black_q[7:0];
          2'd1:    data_d = {2'b00, black_q[13:8]};
          default: data_d = reps_q;
        endcase
        if (byte_cnt_q == 2'd2) begin
          byte_cnt_d = 2'd0;
          state_d    = ST_CTRL_ST;
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      ST_CTRL_ST: begin
        if (byte_cnt_q == 2'd0) begin
          valid_d    = 5'b01000;
          data_d     = {7'b1010000, ccd_q};
          byte_cnt_d = 2'd1;
        end else if (bus.dut_state == 3'd1) begin
          byte_cnt_d = 2'd0;
          smp_cnt_d  = '0;
          state_d    = ST_SAMPLES;
        end
      end
      ST_SAMPLES: begin
        valid_d = 5'b10000;
        if (byte_cnt_q == 2'd0) begin
          data_d     = sample_q[7:0];
          byte_cnt_d = 2'd1;
        end else begin
          data_d     = {2'b00, sample_q[13:8]};
          sample_d   = sample_q + step_q;
          smp_cnt_d  = smp_next;
          byte_cnt_d = 2'd0;
          if (smp_next == n_samples_q) begin
            state_d = ST_CTRL_SP;
          end
        end
      end
      ST_CTRL_SP: begin
        valid_d = 5'b01000;
        data_d  = 8'h55;
        state_d = ST_WAIT_DAC;
      end
      ST_WAIT_DAC: begin
        if (bus.dut_state == 3'd3) begin
          byte_cnt_d = 2'd0;
          state_d    = ST_CTRL_RQ;
        end
      end
      ST_CTRL_RQ: begin
        if (byte_cnt_q == 2'd0) begin
          valid_d    = 5'b01000;
          data_d     = 8'h5A;
          byte_cnt_d = 2'd1;
        end else if (bus.dut_state == 3'd4) begin
          byte_cnt_d = 2'd0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (!rdreq_q) begin
          if (bus.have_msg_bus[4]) begin
            rdreq_d = 1'b1;
          end else if (bus.dut_state == 3'd0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ABORTED: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wd_expired || (abort && (state_q inside {ST_CFG, ST_CTRL_ST, ST_SAMPLES,
        ST_CTRL_SP, ST_WAIT_DAC, ST_CTRL_RQ, ST_READ}))) begin
      state_d = ST_ABORTED;
      valid_d = 5'b00000;
      rdreq_d = 1'b0;
      data_d  = data_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b1;
    end
  end

  // State, configuration, strobe and result registers
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      smp_cnt_q   <= '0;
      n_samples_q <= '0;
      sample_q    <= '0;
      step_q      <= '0;
      black_q     <= '0;
      reps_q      <= '0;
      ccd_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= '0;
      rdreq_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rx_count_q  <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      n_samples_q <= n_samples_d;
      sample_q    <= sample_d;
      step_q      <= step_d;
      black_q     <= black_d;
      reps_q      <= reps_d;
      ccd_q       <= ccd_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      rdreq_q     <= rdreq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rx_count_q  <= rx_count_d;
      checksum_q  <= checksum_d;
    end
  end

  assign bus.master_data = data_q;
  assign bus.valid_bus   = valid_q;
  assign bus.rdreq_bus   = {rdreq_q, 4'b0000};
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign rx_count        = rx_count_q;
  assign checksum        = checksum_q;

endmodule

// File: tb/tb_func_test_sequencer.sv
// Testbench for func_test_sequencer: a behavioural functional-test block answers
// the command bytes, a monitor logs every strobe, and table-driven runs plus
// hand-written abort/reset/timeout sequences compare against hand-computed values.
// Build with SEQ_TIMEOUT_EN defined to also exercise the watchdog (64 cycles).
`timescale 1ns/1ps
module tb_func_test_sequencer;

  logic        sys_clk = 1'b0;
  logic        n_rst;
  logic        start, abort, ccd_mode;
  logic [13:0] black_level, pat_base, pat_step;
  logic [7:0]  num_reps;
  logic [8:0]  num_samples;
  logic        busy, done, error;
  logic [15:0] rx_count, checksum;

  func_test_sequencer_if bus_if();

`ifdef SEQ_TIMEOUT_EN
  func_test_sequencer #(.N_SAMPLES_MAX(256), .TIMEOUT_CYCLES(64)) dut (
`else
  func_test_sequencer #(.N_SAMPLES_MAX(256)) dut (
`endif
    .sys_clk(sys_clk), .n_rst(n_rst), .start(start), .abort(abort),
    .ccd_mode(ccd_mode), .black_level(black_level), .num_reps(num_reps),
    .num_samples(num_samples), .pat_base(pat_base), .pat_step(pat_step),
    .bus(bus_if), .busy(busy), .done(done), .error(error),
    .rx_count(rx_count), .checksum(checksum)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [13:0] bl;
    logic [7:0]  reps;
    logic        ccd;
    logic [8:0]  nsamp;
    logic [13:0] base;
    logic [13:0] step;
    logic [31:0] rx_bytes;
    int          rx_n;
    logic [23:0] exp_cfg;
    logic [23:0] exp_ctrl;
    logic [47:0] exp_smp;
    int          exp_smp_n;
    logic [15:0] exp_rx_count;
    logic [15:0] exp_checksum;
  } vec_t;

  vec_t vecs[3];

  int checks = 0;
  int errors = 0;

  logic [7:0] log_cfg[$];
  logic [7:0] log_ctrl[$];
  logic [7:0] log_smp[$];
  int rdreq_cnt = 0;
  int done_cnt  = 0;
  int viol_cnt  = 0;

  bit          hold_dac = 1'b0;
  logic [31:0] rx_bytes_cur = '0;
  int          rx_n_cur = 0;
  int          load_req = 0;

  function automatic logic [47:0] pack_q(input logic [7:0] q[$], input int from);
    logic [47:0] r;
    r = '0;
    for (int i = from; i < q.size() && i < from + 6; i++) r = {r[39:0], q[i]};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] actual,
                             input logic [47:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx);
    black_level  = vecs[idx].bl;
    num_reps     = vecs[idx].reps;
    ccd_mode     = vecs[idx].ccd;
    num_samples  = vecs[idx].nsamp;
    pat_base     = vecs[idx].base;
    pat_step     = vecs[idx].step;
    rx_bytes_cur = vecs[idx].rx_bytes;
    rx_n_cur     = vecs[idx].rx_n;
    load_req++;
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge sys_clk);
      if (done) ok = 1'b1;
    end
    checkOutput(name, 48'(ok), 48'd1);
  endtask

  task automatic waitStrobe(input string name, input int bit_idx, input logic [7:0] val,
                            input bit match_val);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge sys_clk);
      if (bus_if.valid_bus[bit_idx] && (!match_val || bus_if.master_data == val)) ok = 1'b1;
    end
    checkOutput(name, 48'(ok), 48'd1);
  endtask

  // Behavioural functional-test block: reacts to command bytes, serves captured bytes
  initial begin
    logic [7:0] rxq[$];
    int   delay;
    logic [2:0] target;
    bit   pop_pending;
    int   load_seen;
    load_seen = 0;
    delay = 0; target = 3'd0; pop_pending = 1'b0;
    bus_if.dut_state = 3'd0;
    bus_if.have_msg_bus = 5'b0;
    bus_if.slave_data_bus = 40'h00_DEAD_BEEF;
    forever begin
      @(negedge sys_clk);
      if (!n_rst) begin
        rxq.delete();
        delay = 0; pop_pending = 1'b0;
        bus_if.dut_state = 3'd0;
        bus_if.have_msg_bus = 5'b0;
        bus_if.slave_data_bus = 40'h00_DEAD_BEEF;
      end else begin
        if (load_req != load_seen) begin
          load_seen = load_req;
          rxq.delete();
          for (int i = 0; i < rx_n_cur; i++) rxq.push_back(rx_bytes_cur[8*i +: 8]);
        end
        if (pop_pending) begin
          pop_pending = 1'b0;
          if (rxq.size() > 0) void'(rxq.pop_front());
          bus_if.have_msg_bus[4] = (rxq.size() > 0);
          bus_if.slave_data_bus[39:32] = (rxq.size() > 0) ? rxq[0] : 8'h00;
          if (rxq.size() == 0 && bus_if.dut_state == 3'd4) begin
            target = 3'd0; delay = 3;
          end
        end
        if (bus_if.rdreq_bus[4]) pop_pending = 1'b1;
        if (bus_if.valid_bus[3]) begin
          if (bus_if.master_data[7:1] == 7'b1010000) begin
            target = 3'd1; delay = 3;
          end else if (bus_if.master_data == 8'h55) begin
            bus_if.dut_state = 3'd2; target = 3'd3; delay = 5;
          end else if (bus_if.master_data == 8'h5A) begin
            target = 3'd4; delay = 2;
          end
        end
        if (delay > 0) begin
          if (!(target == 3'd3 && hold_dac)) delay--;
          if (delay == 0) begin
            bus_if.dut_state = target;
            if (target == 3'd4) begin
              bus_if.have_msg_bus[4] = (rxq.size() > 0);
              bus_if.slave_data_bus[39:32] = (rxq.size() > 0) ? rxq[0] : 8'h00;
              if (rxq.size() == 0) begin
                target = 3'd0; delay = 2;
              end
            end
          end
        end
      end
    end
  end

  // Strobe monitor: logs issued bytes and counts protocol violations
  initial begin
    bit prev_rd;
    prev_rd = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (n_rst) begin
        if (bus_if.valid_bus[2]) log_cfg.push_back(bus_if.master_data);
        if (bus_if.valid_bus[3]) log_ctrl.push_back(bus_if.master_data);
        if (bus_if.valid_bus[4]) log_smp.push_back(bus_if.master_data);
        if ($countones(bus_if.valid_bus) > 1 || bus_if.valid_bus[1:0] != 2'b00 ||
            bus_if.rdreq_bus[3:0] != 4'b0000) viol_cnt++;
        if (bus_if.rdreq_bus[4]) begin
          rdreq_cnt++;
          if (prev_rd) viol_cnt++;
        end
        prev_rd = bus_if.rdreq_bus[4];
        if (done) done_cnt++;
      end else begin
        prev_rd = 1'b0;
      end
    end
  end

  // Global safety limit
  initial begin
    #500us;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] global time limit reached");
  end

  // Main test sequence
  initial begin
    int cfg_b, ctrl_b, smp_b, rd_b, done_b, viol_b, total_b, n;
    bit seen;

    vecs[0] = '{14'h1234, 8'h08, 1'b1, 9'd3, 14'h3FFE, 14'h0001, 32'hFF030201, 4,
                24'h341208, 24'hA1555A, 48'hFE3FFF3F0000, 6, 16'd4, 16'h0105};
    vecs[1] = '{14'h3FFF, 8'hFF, 1'b0, 9'd0, 14'h2AB5, 14'h0100, 32'h00008080, 2,
                24'hFF3FFF, 24'hA0555A, 48'h00000000B52A, 2, 16'd2, 16'h0100};
    vecs[2] = '{14'h0001, 8'h00, 1'b1, 9'd2, 14'h0010, 14'h3FFF, 32'h00000000, 0,
                24'h010000, 24'hA1555A, 48'h000010000F00, 4, 16'd0, 16'h0000};

    n_rst = 1'b0; start = 1'b0; abort = 1'b0; ccd_mode = 1'b0;
    black_level = '0; num_reps = '0; num_samples = '0; pat_base = '0; pat_step = '0;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_flags", {busy, done, error}, 48'd0);
    checkOutput("reset_counts", {rx_count, checksum}, 48'd0);
    checkOutput("reset_bus", {bus_if.valid_bus, bus_if.rdreq_bus, bus_if.master_data}, 48'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int v = 0; v < 3; v++) begin
      cfg_b = log_cfg.size(); ctrl_b = log_ctrl.size(); smp_b = log_smp.size();
      rd_b = rdreq_cnt; done_b = done_cnt; viol_b = viol_cnt;
      $display("[TB] vector %0d", v);
      applyStimulus(v);
      checkOutput("busy_after_start", 48'(busy), 48'd1);
      waitStrobe("ctrl_start_seen", 3, 8'h00, 1'b0);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      waitDone("run_done");
      repeat (4) @(negedge sys_clk);
      checkOutput("cfg_count", 48'(log_cfg.size() - cfg_b), 48'd3);
      checkOutput("cfg_bytes", pack_q(log_cfg, cfg_b), 48'(vecs[v].exp_cfg));
      checkOutput("ctrl_count", 48'(log_ctrl.size() - ctrl_b), 48'd3);
      checkOutput("ctrl_bytes", pack_q(log_ctrl, ctrl_b), 48'(vecs[v].exp_ctrl));
      checkOutput("smp_count", 48'(log_smp.size() - smp_b), 48'(vecs[v].exp_smp_n));
      checkOutput("smp_bytes", pack_q(log_smp, smp_b), vecs[v].exp_smp);
      checkOutput("rdreq_count", 48'(rdreq_cnt - rd_b), 48'(vecs[v].rx_n));
      checkOutput("rx_count", 48'(rx_count), 48'(vecs[v].exp_rx_count));
      checkOutput("checksum", 48'(checksum), 48'(vecs[v].exp_checksum));
      checkOutput("done_pulses", 48'(done_cnt - done_b), 48'd1);
      checkOutput("end_flags", {busy, error}, 48'd0);
      checkOutput("protocol_violations", 48'(viol_cnt - viol_b), 48'd0);
    end

    $display("[TB] abort mid-configuration");
    cfg_b = log_cfg.size();
    applyStimulus(0);
    waitStrobe("first_cfg_seen", 2, 8'h00, 1'b0);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    checkOutput("abort_cfg_strobe", 48'(bus_if.valid_bus), 48'd0);
    checkOutput("abort_cfg_flags", {busy, error}, 48'b01);
    repeat (3) @(negedge sys_clk);
    checkOutput("abort_cfg_bytes", 48'(log_cfg.size() - cfg_b), 48'd1);

    $display("[TB] abort during DAC wait");
    hold_dac = 1'b1;
    applyStimulus(2);
    checkOutput("restart_clears_error", 48'(error), 48'd0);
    waitStrobe("stop_byte_seen", 3, 8'h55, 1'b1);
    repeat (3) @(negedge sys_clk);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    checkOutput("abort_dac_flags", {busy, error}, 48'b01);
    total_b = log_cfg.size() + log_ctrl.size() + log_smp.size() + rdreq_cnt;
    repeat (5) @(negedge sys_clk);
    checkOutput("abort_dac_quiet",
                48'(log_cfg.size() + log_ctrl.size() + log_smp.size() + rdreq_cnt - total_b),
                48'd0);
    hold_dac = 1'b0;
    applyStimulus(2);
    checkOutput("start_clears_error", {busy, error}, 48'b10);
    waitDone("rerun_done");
    repeat (2) @(negedge sys_clk);

    $display("[TB] abort in idle, abort with start");
    abort = 1'b1;
    repeat (2) @(negedge sys_clk);
    abort = 1'b0;
    checkOutput("idle_abort_ignored", {busy, error}, 48'd0);
    load_req++;
    start = 1'b1; abort = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start_beats_abort", {busy, error}, 48'b10);
    waitDone("start_abort_done");
    repeat (2) @(negedge sys_clk);

    $display("[TB] reset mid-samples");
    applyStimulus(0);
    waitStrobe("sample_seen", 4, 8'h00, 1'b0);
    n_rst = 1'b0;
    #1;
    checkOutput("reset_async_bus", {bus_if.valid_bus, bus_if.rdreq_bus, bus_if.master_data},
                48'd0);
    @(negedge sys_clk);
    checkOutput("reset_mid_outputs", {busy, done, error, rx_count, checksum}, 48'd0);
    n_rst = 1'b1;
    total_b = log_cfg.size() + log_ctrl.size() + log_smp.size() + rdreq_cnt;
    repeat (6) @(negedge sys_clk);
    checkOutput("post_reset_quiet",
                48'(log_cfg.size() + log_ctrl.size() + log_smp.size() + rdreq_cnt - total_b),
                48'd0);
    checkOutput("post_reset_busy", 48'(busy), 48'd0);

`ifdef SEQ_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    hold_dac = 1'b1;
    applyStimulus(2);
    waitStrobe("timeout_stop_seen", 3, 8'h55, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge sys_clk);
      n++;
      if (error) seen = 1'b1;
    end
    checkOutput("timeout_error", 48'(seen), 48'd1);
    checkOutput("timeout_window", 48'(n >= 60 && n <= 70), 48'd1);
    checkOutput("timeout_busy", 48'(busy), 48'd0);
    hold_dac = 1'b0;
`else
    n = 0;
    seen = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
